// File: rtl/blink_timebase.sv
// Timebase for the blinker: free-running prescaled count plus a per-instance phase offset.
// Latency: all outputs registered, one cycle after the causing edge; offset updates land on a wrap boundary.
// Backpressure: load_ready is low while an offset is pending; it rises again after the next wrap or count_clear.
module blink_timebase #(
    parameter int COUNT_W = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               count_clear,
    input  logic               load_valid,
    input  logic [COUNT_W-1:0] load_data,
    output logic               load_ready,
    input  logic               sweep_en,
    input  logic [COUNT_W-1:0] sweep_step,
    output logic [COUNT_W-1:0] current_count,
    output logic [COUNT_W-1:0] offset,
    output logic               tick,
    output logic               wrap
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] psc_q, psc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] offset_q, offset_d;
    logic [COUNT_W-1:0] pending_q, pending_d;
    logic               tick_q, tick_d;
    logic               wrap_q, wrap_d;
    logic               tick_evt;
    logic               boundary;

    always_comb begin
        psc_d    = psc_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        tick_evt = 1'b0;
        if (count_clear) begin
            psc_d   = '0;
            count_d = '0;
        end else if (ena) begin
            if (psc_q == prescale) begin
                psc_d    = '0;
                tick_evt = 1'b1;
            end else if (psc_q > prescale) begin
                // prescale shrank below the running count: restart without a tick
                psc_d = '0;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
        if (tick_evt) begin
            count_d = count_q + 1'b1;
            tick_d  = 1'b1;
            wrap_d  = (count_q == '1);
        end
    end

    assign boundary   = count_clear | (tick_evt & (count_q == '1));
    assign load_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    pending_d = load_data;
                    state_d   = PEND;
                end else if (boundary && sweep_en) begin
                    offset_d = offset_q + sweep_step;
                end
            end
            PEND: begin
                // a pending load replaces the sweep step at this boundary
                if (boundary) begin
                    offset_d = pending_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            psc_q     <= '0;
            count_q   <= '0;
            offset_q  <= '0;
            pending_q <= '0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            count_q   <= count_d;
            offset_q  <= offset_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
        end
    end

    assign current_count = count_q;
    assign offset        = offset_q;
    assign tick          = tick_q;
    assign wrap          = wrap_q;

endmodule

// File: doc/blink_timebase.md
Name: blink_timebase

Overview:
Upstream timebase for the blinker stage. Generates the shared free-running current_count and a per-instance offset, both registered. The blinker consumes them and derives blink_wire from bit 9 of their sum. Offset changes are deferred to count wrap, so a phase change never produces a runt blink. An optional automatic phase sweep adds a fixed step to the offset on every wrap.

Parameters:
COUNT_W, 16, width of current_count, offset and sweep_step; the blinker requires 16.
PRESC_W, 8, width of the prescale input and the internal prescale counter.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
ena  input  1  count enable; low freezes the prescaler and the count.
prescale  input  PRESC_W  tick divider; a tick fires every prescale+1 enabled cycles.
count_clear  input  1  synchronous clear of the count and the prescaler.
load_valid  input  1  new offset offered.
load_data  input  COUNT_W  offset value offered.
load_ready  output  1  block can accept an offset this cycle.
sweep_en  input  1  enable automatic offset stepping at wrap.
sweep_step  input  COUNT_W  amount added to offset per wrap.
current_count  output  COUNT_W  to blinker currentCount.
offset  output  COUNT_W  to blinker offset.
tick  output  1  one-cycle pulse, registered, in the cycle current_count changes.
wrap  output  1  one-cycle pulse in the cycle current_count changes from all-ones to 0.

Behaviour:
- Reset (async assert, sync release): current_count=0, offset=0, prescale counter=0, tick=0, wrap=0, FSM=IDLE, load_ready=1, pending register=0.
- Prescaler (ena=1):
  - psc counts 0..prescale.
  - When psc==prescale: psc<=0 and the count advances (tick event); otherwise psc<=psc+1.
  - prescale=0 gives a tick every enabled cycle.
  - A prescale change mid-count: if psc>prescale, psc<=0 with no tick that cycle.
- Count: on a tick event, current_count<=current_count+1 mod 2^COUNT_W. tick=1 that same cycle; wrap=1 that cycle if the old value was all-ones.
- ena=0: psc, current_count and offset are held; tick=wrap=0. The handshake still operates.
- count_clear: has priority over the tick.
  - psc<=0, current_count<=0, tick=wrap=0 that cycle.
  - It is treated as a wrap boundary for the offset update (see below).
- Offset FSM:
  - IDLE: load_ready=1.
    - load_valid&load_ready: capture load_data into pending, go to PEND.
    - This cycle's wrap, if any, does not apply the new value.
    - Else on a wrap boundary with sweep_en=1: offset<=offset+sweep_step mod 2^COUNT_W.
  - PEND: load_ready=0; load_valid is ignored.
    - On a wrap boundary (wrap event or count_clear): offset<=pending, go to IDLE.
    - Load beats sweep: no sweep step is applied at that boundary.
- Latency:
  - Load accepted in cycle N: offset shows pending in the cycle after the first wrap boundary later than N.
  - count_clear in PEND: offset updates the next cycle.
- Reset mid-PEND: pending is discarded and offset returns to 0.
- All outputs are registered; there is no combinational input-to-output path except load_ready, which is decoded from state.

Test Plan:
- Reset, ena=1, prescale=0: after 10 clocks current_count=10 and tick=1 every cycle; after 512 ticks current_count[9]=1.
- prescale=3, ena=1: current_count increments every 4th cycle; toggle ena low for 5 cycles -> count and psc frozen; resumes with the same phase.
- Count reaches 0xFFFF, then one tick: current_count=0 and wrap=1 for exactly one cycle; wrap=0 on all other ticks.
- load 0x0100 while count=0x1234 -> load_ready drops next cycle; offset stays 0 until wrap, then offset=0x0100 and load_ready=1; a second load offered during PEND is not accepted.
- sweep_en=1, sweep_step=0x0040, three wraps -> offset=0x00C0; a load of 0x0005 pending at the 4th wrap -> offset=0x0005, not 0x0100.
- In PEND with pending=0x0200, assert count_clear -> next cycle current_count=0, offset=0x0200, wrap=0; assert rst in PEND -> offset=0 immediately, FSM=IDLE.
